// File: rtl/qam_mapper_if.sv
// Bit-stream handshake and symbol output bundle for qam_mapper.
//  bit_in/bit_valid/bit_ready : serial bit input with valid/ready handshake
//  I_out/Q_out                : signed 8-bit symbol samples, held between symbols
//  sym_valid/underflow        : 1-cycle pulses accompanying each emitted symbol
// master: the side that drives bits and consumes symbols; slave: the mapper.
interface qam_mapper_if;
  logic              bit_in;
  logic              bit_valid;
  logic              bit_ready;
  logic signed [7:0] I_out;
  logic signed [7:0] Q_out;
  logic              sym_valid;
  logic              underflow;

  modport master (
    output bit_in, bit_valid,
    input  bit_ready, I_out, Q_out, sym_valid, underflow
  );

  modport slave (
    input  bit_in, bit_valid,
    output bit_ready, I_out, Q_out, sym_valid, underflow
  );
endinterface

// File: rtl/qam_mapper.sv
// Transmit-side 16QAM hard mapper: packs a serial bit stream into nibbles,
// queues them in a small FIFO, and emits one Gray-mapped I/Q symbol every
// SYM_PERIOD cycles, optionally preceded by a burst of (0,0) calibration symbols.
// Ports:
//  symbol_clock : clock, rising edge
//  rst          : synchronous active-high reset
//  en           : block enable; low forces IDLE (FIFO and partial nibble kept)
//  cal          : request a CAL_LEN-symbol (0,0) calibration burst
//  sif          : bit handshake in, I/Q symbol + pulses out (slave modport)
//  fifo_level   : number of nibbles currently stored
module qam_mapper #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SYM_PERIOD = 4,
  parameter int unsigned AMP_LO     = 32,
  parameter int unsigned AMP_HI     = 96,
  parameter int unsigned CAL_LEN    = 16
) (
  input  logic                        symbol_clock,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        cal,
  qam_mapper_if.slave                 sif,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;
  localparam int unsigned CW = $clog2(CAL_LEN + 1);

  localparam logic signed [7:0] P_LO = 8'(AMP_LO);
  localparam logic signed [7:0] P_HI = 8'(AMP_HI);
  localparam logic signed [7:0] N_LO = 8'(-int'(AMP_LO));
  localparam logic signed [7:0] N_HI = 8'(-int'(AMP_HI));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAL  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [CW-1:0]     cal_cnt;
  logic [CW-1:0]     cal_cnt_nxt;
  logic [1:0]        bit_cnt;
  logic [2:0]        nib_lo;
  logic [3:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              full;
  logic              empty;
  logic              bit_take;
  logic              push;
  logic              pop;
  logic [3:0]        head;
  logic signed [7:0] i_nxt;
  logic signed [7:0] q_nxt;
  logic              sym_nxt;
  logic              uf_nxt;

  assign full          = (fifo_level == LW'(FIFO_DEPTH));
  assign empty         = (fifo_level == '0);
  assign sif.bit_ready = en & ~full & ~rst;
  assign bit_take      = sif.bit_valid & sif.bit_ready;
  // The fourth accepted bit completes the nibble and goes straight into the FIFO.
  assign push          = bit_take & (bit_cnt == 2'd3);
  assign head          = mem[rd_ptr];
  assign tick          = (state != IDLE) && (tick_cnt == TW'(SYM_PERIOD - 1));

  // Symbol-period counter; idles at 0 so the first symbol comes a full period after leaving IDLE.
  always_ff @(posedge symbol_clock) begin
    if (rst || state == IDLE) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= TW'(tick_cnt + 1'b1);
    end
  end

  // Serial-to-nibble assembler: first accepted bit lands in nib[0].
  always_ff @(posedge symbol_clock) begin
    if (rst) begin
      bit_cnt <= '0;
      nib_lo  <= '0;
    end else if (bit_take) begin
      case (bit_cnt)
        2'd0:    nib_lo[0] <= sif.bit_in;
        2'd1:    nib_lo[1] <= sif.bit_in;
        2'd2:    nib_lo[2] <= sif.bit_in;
        default: nib_lo    <= nib_lo;
      endcase
      bit_cnt <= 2'(bit_cnt + 1'b1);
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge symbol_clock) begin
    if (push) begin
      mem[wr_ptr] <= {sif.bit_in, nib_lo};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge symbol_clock) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= AW'(wr_ptr + 1'b1);
      end
      if (pop) begin
        rd_ptr <= AW'(rd_ptr + 1'b1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= LW'(fifo_level + 1'b1);
        2'b01:   fifo_level <= LW'(fifo_level - 1'b1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // State register.
  always_ff @(posedge symbol_clock) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; dropping en wins over everything else.
  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = cal ? CAL : RUN;
        CAL:     if (tick && cal_cnt == CW'(CAL_LEN - 1)) state_nxt = RUN;
        RUN:     if (cal) state_nxt = CAL;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic: next symbol registers, FIFO pop and calibration count.
  always_comb begin
    i_nxt       = sif.I_out;
    q_nxt       = sif.Q_out;
    sym_nxt     = 1'b0;
    uf_nxt      = 1'b0;
    pop         = 1'b0;
    cal_cnt_nxt = cal_cnt;
    if (!en || state == IDLE) begin
      i_nxt       = '0;
      q_nxt       = '0;
      cal_cnt_nxt = '0;
    end else begin
      case (state)
        CAL: begin
          if (tick) begin
            i_nxt       = '0;
            q_nxt       = '0;
            sym_nxt     = 1'b1;
            cal_cnt_nxt = (cal_cnt == CW'(CAL_LEN - 1)) ? '0 : CW'(cal_cnt + 1'b1);
          end
        end
        RUN: begin
          if (tick) begin
            sym_nxt = 1'b1;
            if (empty) begin
              // Starved: emit origin and flag it; read pointer stays put.
              i_nxt  = '0;
              q_nxt  = '0;
              uf_nxt = 1'b1;
            end else begin
              pop   = 1'b1;
              // Gray map: nib[3]/nib[1] pick sign, nib[2]/nib[0] pick inner level.
              i_nxt = head[3] ? (head[2] ? P_LO : P_HI) : (head[2] ? N_LO : N_HI);
              q_nxt = head[1] ? (head[0] ? N_LO : N_HI) : (head[0] ? P_LO : P_HI);
            end
          end
          if (cal) begin
            cal_cnt_nxt = '0;
          end
        end
        default: begin
          i_nxt = '0;
          q_nxt = '0;
        end
      endcase
    end
  end

  // Registered symbol outputs.
  always_ff @(posedge symbol_clock) begin
    if (rst) begin
      sif.I_out     <= '0;
      sif.Q_out     <= '0;
      sif.sym_valid <= 1'b0;
      sif.underflow <= 1'b0;
      cal_cnt       <= '0;
    end else begin
      sif.I_out     <= i_nxt;
      sif.Q_out     <= q_nxt;
      sif.sym_valid <= sym_nxt;
      sif.underflow <= uf_nxt;
      cal_cnt       <= cal_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_qam_mapper.sv
// Directed self-checking bench for qam_mapper: a default instance for mapping,
// calibration, reset and enable behaviour, and a SYM_PERIOD=64 instance for
// FIFO back-pressure.
module tb_qam_mapper;

  typedef struct {
    logic              uf;
    logic signed [7:0] i;
    logic signed [7:0] q;
    int                cyc;
  } sym_t;

  logic       symbol_clock = 1'b0;
  logic       rst;
  logic       en;
  logic       cal;
  logic       en64;
  logic       cal64;
  logic [3:0] fifo_level;
  logic [3:0] fifo_level64;

  qam_mapper_if bif ();
  qam_mapper_if bif64 ();

  qam_mapper dut (
    .symbol_clock (symbol_clock),
    .rst          (rst),
    .en           (en),
    .cal          (cal),
    .sif          (bif),
    .fifo_level   (fifo_level)
  );

  qam_mapper #(.SYM_PERIOD(64)) dut64 (
    .symbol_clock (symbol_clock),
    .rst          (rst),
    .en           (en64),
    .cal          (cal64),
    .sif          (bif64),
    .fifo_level   (fifo_level64)
  );

  always #5 symbol_clock = ~symbol_clock;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   acc64  = 0;
  sym_t sq[$];

  // Hand-built mapping table: I by nib[3:2], Q by nib[1:0].
  int i_lut[4] = '{-96, -32, 96, 32};
  int q_lut[4] = '{96, 32, -96, -32};

  always @(posedge symbol_clock) cyc <= cyc + 1;

  // Symbol monitor for the default instance.
  always @(negedge symbol_clock) begin
    if (bif.sym_valid) sq.push_back('{bif.underflow, bif.I_out, bif.Q_out, cyc});
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge after the bit is accepted.
  task automatic send_bit(input logic b);
    int g = 0;
    bif.bit_in    = b;
    bif.bit_valid = 1'b1;
    #1;
    while (!bif.bit_ready && g < 200) begin
      @(negedge symbol_clock);
      #1;
      g++;
    end
    if (g >= 200) check_eq("bit_accept_timeout", 0, 1);
    @(negedge symbol_clock);
    bif.bit_valid = 1'b0;
  endtask

  task automatic send_nib(input logic [3:0] n);
    for (int k = 0; k < 4; k++) send_bit(n[k]);
  endtask

  task automatic wait_q(input int n, output bit ok);
    int g = 0;
    while (sq.size() < n && g < 400) begin
      @(negedge symbol_clock);
      #1;
      g++;
    end
    ok = (sq.size() >= n);
    if (!ok) check_eq("sym_timeout", sq.size(), n);
  endtask

  // Next non-underflow symbol from the monitor.
  task automatic wait_data(output sym_t s);
    int g   = 0;
    bit got = 1'b0;
    s = '{1'b1, 8'sd0, 8'sd0, 0};
    while (!got && g < 100) begin
      if (sq.size() > 0) begin
        s = sq.pop_front();
        if (!s.uf) got = 1'b1;
      end else begin
        @(negedge symbol_clock);
        #1;
        g++;
      end
    end
    if (!got) check_eq("data_timeout", 0, 1);
  endtask

  task automatic step64();
    if (bif64.bit_valid && bif64.bit_ready) acc64++;
    @(negedge symbol_clock);
    #1;
  endtask

  initial begin
    sym_t       s;
    bit         ok;
    logic [3:0] dm;
    int         zeros;
    int         gaps;
    int         g;

    rst = 1'b1; en = 1'b0; cal = 1'b0; en64 = 1'b0; cal64 = 1'b0;
    bif.bit_in = 1'b0; bif.bit_valid = 1'b0;
    bif64.bit_in = 1'b0; bif64.bit_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge symbol_clock);
    check_eq("rst_i", bif.I_out, 0);
    check_eq("rst_q", bif.Q_out, 0);
    check_eq("rst_sym_valid", bif.sym_valid, 0);
    check_eq("rst_underflow", bif.underflow, 0);
    check_eq("rst_level", fifo_level, 0);
    en = 1'b1;
    #1;
    check_eq("rst_bit_ready", bif.bit_ready, 0);

    // Bits 0,1,0,1 -> (+96,-96), then underflows every 4 cycles
    @(negedge symbol_clock);
    rst = 1'b0;
    sq.delete();
    send_nib(4'b1010);
    wait_q(3, ok);
    if (ok) begin
      check_eq("t1_uf0", sq[0].uf, 0);
      check_eq("t1_i0", sq[0].i, 96);
      check_eq("t1_q0", sq[0].q, -96);
      check_eq("t1_uf1", sq[1].uf, 1);
      check_eq("t1_i1", sq[1].i, 0);
      check_eq("t1_q1", sq[1].q, 0);
      check_eq("t1_gap1", sq[1].cyc - sq[0].cyc, 4);
      check_eq("t1_uf2", sq[2].uf, 1);
      check_eq("t1_gap2", sq[2].cyc - sq[1].cyc, 4);
    end

    // All 16 nibbles against the table, plus re-demap with thresholds 0 / +-64
    for (int n = 0; n < 16; n++) begin
      sq.delete();
      send_nib(4'(n));
      wait_data(s);
      check_eq($sformatf("map_i_%0d", n), s.i, i_lut[n >> 2]);
      check_eq($sformatf("map_q_%0d", n), s.q, q_lut[n & 3]);
      dm = {s.i > 0, (s.i > -64) && (s.i < 64), s.q < 0, (s.q > -64) && (s.q < 64)};
      check_eq($sformatf("demap_%0d", n), dm, n);
    end

    // Calibration burst: 16 x (0,0) four cycles apart, then queued nibble 1100
    @(negedge symbol_clock);
    en = 1'b0;
    repeat (2) @(negedge symbol_clock);
    sq.delete();
    en = 1'b1; cal = 1'b1;
    @(negedge symbol_clock);
    cal = 1'b0;
    send_nib(4'b1100);
    wait_q(17, ok);
    if (ok) begin
      zeros = 0;
      gaps  = 0;
      for (int k = 0; k < 16; k++)
        if (!sq[k].uf && sq[k].i == 0 && sq[k].q == 0) zeros++;
      for (int k = 1; k < 17; k++)
        if (sq[k].cyc - sq[k-1].cyc == 4) gaps++;
      check_eq("cal_zero_syms", zeros, 16);
      check_eq("cal_gaps", gaps, 16);
      check_eq("cal_next_uf", sq[16].uf, 0);
      check_eq("cal_next_i", sq[16].i, 32);
      check_eq("cal_next_q", sq[16].q, 96);
    end

    // en dropped mid-RUN with 2 nibbles stored, then re-enabled
    @(negedge symbol_clock);
    en = 1'b0;
    repeat (2) @(negedge symbol_clock);
    sq.delete();
    en = 1'b1; cal = 1'b1;
    @(negedge symbol_clock);
    cal = 1'b0;
    send_nib(4'b0110);
    send_nib(4'b1001);
    send_nib(4'b1111);
    wait_q(17, ok);
    en = 1'b0;
    if (ok) begin
      check_eq("en_first_i", sq[16].i, -32);
      check_eq("en_first_q", sq[16].q, -96);
    end
    check_eq("en_level", fifo_level, 2);
    repeat (12) @(negedge symbol_clock);
    check_eq("en_no_sym", sq.size(), 17);
    check_eq("en_off_i", bif.I_out, 0);
    check_eq("en_off_q", bif.Q_out, 0);
    check_eq("en_off_sym_valid", bif.sym_valid, 0);
    en = 1'b1;
    wait_q(19, ok);
    if (ok) begin
      check_eq("en_b_uf", sq[17].uf, 0);
      check_eq("en_b_i", sq[17].i, 96);
      check_eq("en_b_q", sq[17].q, 32);
      check_eq("en_c_uf", sq[18].uf, 0);
      check_eq("en_c_i", sq[18].i, 32);
      check_eq("en_c_q", sq[18].q, -32);
    end

    // Reset mid-operation with 3 nibbles + 2 pending bits
    @(negedge symbol_clock);
    en = 1'b0;
    @(negedge symbol_clock);
    en = 1'b1; cal = 1'b1;
    @(negedge symbol_clock);
    cal = 1'b0;
    send_nib(4'b0001);
    send_nib(4'b0010);
    send_nib(4'b0100);
    send_bit(1'b1);
    send_bit(1'b1);
    check_eq("rst_mid_level_before", fifo_level, 3);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_bit_ready", bif.bit_ready, 0);
    @(negedge symbol_clock);
    rst = 1'b0;
    check_eq("rst_mid_i", bif.I_out, 0);
    check_eq("rst_mid_q", bif.Q_out, 0);
    check_eq("rst_mid_sym_valid", bif.sym_valid, 0);
    check_eq("rst_mid_underflow", bif.underflow, 0);
    check_eq("rst_mid_level", fifo_level, 0);
    sq.delete();
    send_nib(4'b0011);
    wait_data(s);
    check_eq("rst_fresh_i", s.i, -96);
    check_eq("rst_fresh_q", s.q, -32);

    // Back-pressure on the SYM_PERIOD=64 instance
    @(negedge symbol_clock);
    en64 = 1'b1;
    bif64.bit_in = 1'b1;
    bif64.bit_valid = 1'b1;
    #1;
    repeat (40) step64();
    check_eq("bp_accepted", acc64, 32);
    check_eq("bp_level_full", fifo_level64, 8);
    check_eq("bp_ready_full", bif64.bit_ready, 0);
    g = 0;
    while (!bif64.sym_valid && g < 100) begin
      step64();
      g++;
    end
    check_eq("bp_pop_seen", bif64.sym_valid, 1);
    check_eq("bp_pop_i", bif64.I_out, 32);
    check_eq("bp_pop_q", bif64.Q_out, -32);
    check_eq("bp_level_after_pop", fifo_level64, 7);
    check_eq("bp_ready_after_pop", bif64.bit_ready, 1);
    repeat (6) step64();
    check_eq("bp_accepted_refill", acc64, 36);
    check_eq("bp_level_refill", fifo_level64, 8);
    check_eq("bp_ready_refill", bif64.bit_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
